// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester and RegisterFile write-port bundle for the write arbiter
interface regfile_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_stall;
  logic                  we3;
  logic [AW-1:0]         wa3;
  logic [WIDTH-1:0]      wd3;
  logic [GW-1:0]         grant_id;
  logic                  zero_drop;
  logic                  locked;

  modport master (
    output req_valid, req_lock, req_addr, req_data, wr_stall,
    input  req_ready, we3, wa3, wd3, grant_id, zero_drop, locked
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data, wr_stall,
    output req_ready, we3, wa3, wd3, grant_id, zero_drop, locked
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter with lockable bursts for the RegisterFile write port
module regfile_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int AW      = 3,
  parameter int LOCK_TO = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_TO + 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t           state, state_next;
  logic [GW-1:0]    owner, owner_next;
  logic [GW-1:0]    rr_ptr, rr_next;
  logic [CW-1:0]    lock_cnt, cnt_next;
  logic [NREQ-1:0]  ready;
  logic             accept;
  logic [GW-1:0]    acc_idx;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] v);
    return (v == GW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Grant is at most one-hot; a grant is an accept because ready implies valid.
  always_comb begin
    int scan;
    ready   = '0;
    accept  = 1'b0;
    acc_idx = '0;
    scan    = 0;
    if (rst_n && !bus.wr_stall) begin
      if (state == ST_LOCKED) begin
        if (bus.req_valid[owner]) begin
          ready[owner] = 1'b1;
          accept       = 1'b1;
          acc_idx      = owner;
        end
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          scan = int'(rr_ptr) + i;
          if (scan >= NREQ) scan = scan - NREQ;
          if (!accept && bus.req_valid[scan]) begin
            ready[scan] = 1'b1;
            accept      = 1'b1;
            acc_idx     = GW'(scan);
          end
        end
      end
    end
  end

  assign sel_addr      = bus.req_addr[int'(acc_idx)*AW +: AW];
  assign sel_data      = bus.req_data[int'(acc_idx)*WIDTH +: WIDTH];
  assign bus.req_ready = ready;
  assign bus.locked    = (state == ST_LOCKED);

  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    cnt_next   = lock_cnt;
    if (accept) begin
      rr_next  = next_idx(acc_idx);
      cnt_next = '0;
      if (bus.req_lock[acc_idx]) begin
        state_next = ST_LOCKED;
        owner_next = acc_idx;
      end else begin
        state_next = ST_ARB;
      end
    end else if (state == ST_LOCKED && !bus.wr_stall && !bus.req_valid[owner]) begin
      // Revoke an abandoned lock so the other requesters are not starved.
      if (lock_cnt == CW'(LOCK_TO - 1)) begin
        state_next = ST_ARB;
        rr_next    = next_idx(owner);
        cnt_next   = '0;
      end else begin
        cnt_next = lock_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ARB;
      owner    <= '0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_next;
      lock_cnt <= cnt_next;
    end
  end

  // Writes to r0 are swallowed here and flagged, since r0 is hardwired in the RegisterFile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we3       <= 1'b0;
      bus.wa3       <= '0;
      bus.wd3       <= '0;
      bus.grant_id  <= '0;
      bus.zero_drop <= 1'b0;
    end else begin
      bus.we3       <= accept && (sel_addr != '0);
      bus.zero_drop <= accept && (sel_addr == '0);
      if (accept) begin
        bus.wa3      <= sel_addr;
        bus.wd3      <= sel_data;
        bus.grant_id <= acc_idx;
      end
    end
  end
endmodule
